// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Load/store front-end between the CPU execute stage and generic_mem.
//   Handles one byte, half or word access at a time.
//   - Loads read the containing word, then extract and sign/zero-extend the
//     addressed lane.
//   - Full-word stores are written directly.
//   - Sub-word stores do a read-modify-write, because the memory only
//     writes whole words.
//   - Misaligned or invalid-size requests are flagged without any memory
//     access.
//
// Ports
//   clock, reset       : system clock, synchronous active-high reset
//   req_valid/ready    : request handshake (ready only in IDLE)
//   req_write          : 1 = store, 0 = load
//   req_size           : 00 byte, 01 half, 10 word, 11 invalid
//   req_unsigned       : loads only, 1 = zero-extend, 0 = sign-extend
//   req_addr           : byte address
//   req_wdata          : store data, right-aligned
//   resp_valid         : one-cycle completion pulse
//   resp_error         : misaligned / invalid size, valid with resp_valid
//   resp_rdata         : load result (0 for stores and errors)
//   mem_*              : generic_mem interface; word-aligned address,
//                        read data arrives the cycle after mem_read_en
module mem_access_unit #(
    parameter int  MEMSIZE = 32 * 1024,
    localparam int ADDR_W  = $clog2(MEMSIZE)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_error,
    output logic [31:0]       resp_rdata,
    output logic              mem_write_en,
    output logic              mem_read_en,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_BAD  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        LD_FIN,
        MERGE,
        WR,
        ERR,
        RESP
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              write_q, write_d;
    logic              uns_q, uns_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       merge_q, merge_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_error_q, resp_error_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              req_err;

    // Extract the addressed lane of a memory word and extend it to 32 bits.
    function automatic logic [31:0] extend_lane(input logic [31:0] word,
                                                input logic [1:0]  size,
                                                input logic [1:0]  off,
                                                input logic        uns);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [31:0]        res;
        b = word[8*off +: 8];
        h = word[16*off[1] +: 16];
        case (size)
            SZ_BYTE: res = uns ? {24'b0, b} : 32'(b);
            SZ_HALF: res = uns ? {16'b0, h} : 32'(h);
            default: res = word;
        endcase
        return res;
    endfunction

    // Replace only the addressed lane(s) of the old word with store data.
    function automatic logic [31:0] merge_lane(input logic [31:0] old_word,
                                               input logic [31:0] wd,
                                               input logic [1:0]  size,
                                               input logic [1:0]  off);
        logic [31:0] res;
        res = old_word;
        case (size)
            SZ_BYTE: res[8*off +: 8]     = wd[7:0];
            SZ_HALF: res[16*off[1] +: 16] = wd[15:0];
            default: res = wd;
        endcase
        return res;
    endfunction

    // Byte accesses are never misaligned.
    assign req_err = (req_size == SZ_BAD) ||
                     (req_size == SZ_HALF && req_addr[0]) ||
                     (req_size == SZ_WORD && req_addr[1:0] != 2'b00);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        size_d       = size_q;
        write_d      = write_q;
        uns_d        = uns_q;
        wdata_d      = wdata_q;
        merge_d      = merge_q;
        resp_error_d = resp_error_q;
        resp_rdata_d = resp_rdata_q;
        resp_valid_d = 1'b0;
        req_ready    = 1'b0;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        mem_address  = {addr_q[ADDR_W-1:2], 2'b00};
        mem_wdata    = (size_q == SZ_WORD) ? wdata_q : merge_q;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d  = req_addr;
                    size_d  = req_size;
                    write_d = req_write;
                    uns_d   = req_unsigned;
                    wdata_d = req_wdata;
                    if (req_err)
                        state_d = ERR;
                    else if (req_write && req_size == SZ_WORD)
                        state_d = WR;
                    else
                        state_d = RD;
                end
            end
            RD: begin
                mem_read_en = 1'b1;
                state_d     = write_q ? MERGE : LD_FIN;
            end
            LD_FIN: begin
                resp_rdata_d = extend_lane(mem_rdata, size_q, addr_q[1:0], uns_q);
                resp_error_d = 1'b0;
                state_d      = RESP;
            end
            MERGE: begin
                merge_d = merge_lane(mem_rdata, wdata_q, size_q, addr_q[1:0]);
                state_d = WR;
            end
            WR: begin
                mem_write_en = 1'b1;
                resp_error_d = 1'b0;
                resp_rdata_d = 32'b0;
                state_d      = RESP;
            end
            ERR: begin
                resp_error_d = 1'b1;
                resp_rdata_d = 32'b0;
                state_d      = RESP;
            end
            RESP: begin
                resp_valid_d = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A reset cycle must never start a memory access or a handshake.
        if (reset) begin
            req_ready    = 1'b0;
            mem_read_en  = 1'b0;
            mem_write_en = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            size_q       <= 2'b00;
            write_q      <= 1'b0;
            uns_q        <= 1'b0;
            wdata_q      <= 32'b0;
            merge_q      <= 32'b0;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            resp_rdata_q <= 32'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            write_q      <= write_d;
            uns_q        <= uns_d;
            wdata_q      <= wdata_d;
            merge_q      <= merge_d;
            resp_valid_q <= resp_valid_d;
            resp_error_q <= resp_error_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_error = resp_error_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    localparam int MEMSIZE = 32 * 1024;
    localparam int ADDR_W  = $clog2(MEMSIZE);

    logic              clock = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_error;
    logic [31:0]       resp_rdata;
    logic              mem_write_en;
    logic              mem_read_en;
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    mem_access_unit #(.MEMSIZE(MEMSIZE)) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_error   (resp_error),
        .resp_rdata   (resp_rdata),
        .mem_write_en (mem_write_en),
        .mem_read_en  (mem_read_en),
        .mem_address  (mem_address),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    always #5 clock = ~clock;

    // Word memory behaving like generic_mem: registered read, whole-word write.
    logic [31:0] mem [0:MEMSIZE/4-1];
    always @(posedge clock) begin
        if (mem_write_en) mem[mem_address[ADDR_W-1:2]] <= mem_wdata;
        if (mem_read_en)  mem_rdata <= mem[mem_address[ADDR_W-1:2]];
    end

    typedef struct {
        logic              err;
        logic [31:0]       rdata;
        int                lat;
        int                n_rd;
        int                n_wr;
        logic [ADDR_W-1:0] waddr;
        logic [31:0]       wdata;
        int                acc;
    } exp_t;

    exp_t              sb[$];
    exp_t              e;
    int                tests = 0;
    int                fails = 0;
    int                cyc = 0;
    int                rd_cnt = 0;
    int                wr_cnt = 0;
    logic [ADDR_W-1:0] last_waddr = '0;
    logic [31:0]       last_wdata = 32'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    // Monitor: memory traffic and responses, sampled on the falling edge.
    always @(negedge clock) begin
        if (mem_read_en || mem_write_en) begin
            check("mem_addr_align", 32'(mem_address[1:0]), 32'd0);
            check("mem_rd_wr_excl", 32'(mem_read_en & mem_write_en), 32'd0);
        end
        if (mem_read_en) rd_cnt++;
        if (mem_write_en) begin
            wr_cnt++;
            last_waddr = mem_address;
            last_wdata = mem_wdata;
        end
        if (resp_valid) begin
            check("resp_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("resp_error", 32'(resp_error), 32'(e.err));
                check("resp_rdata", resp_rdata, e.rdata);
                check("latency", 32'(cyc - e.acc), 32'(e.lat));
                check("n_mem_read", 32'(rd_cnt), 32'(e.n_rd));
                check("n_mem_write", 32'(wr_cnt), 32'(e.n_wr));
                if (e.n_wr > 0) begin
                    check("mem_waddr", 32'(last_waddr), 32'(e.waddr));
                    check("mem_wdata", last_wdata, e.wdata);
                end
                rd_cnt = 0;
                wr_cnt = 0;
            end
        end
    end

    // Drive one request (called just after a rising edge) and wait for accept.
    task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                         input logic [ADDR_W-1:0] a, input logic [31:0] wd,
                         input logic e_err, input logic [31:0] e_rdata, input int e_lat,
                         input int e_nrd, input int e_nwr, input logic [31:0] e_wdata,
                         input logic push, input logic hold);
        exp_t x;
        logic acc_ok;
        req_write    = w;
        req_size     = sz;
        req_unsigned = u;
        req_addr     = a;
        req_wdata    = wd;
        req_valid    = 1'b1;
        acc_ok       = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (req_ready) begin
                acc_ok = 1'b1;
                break;
            end
        end
        check("accept", 32'(acc_ok), 32'd1);
        if (acc_ok && push) begin
            x.err   = e_err;
            x.rdata = e_rdata;
            x.lat   = e_lat;
            x.n_rd  = e_nrd;
            x.n_wr  = e_nwr;
            x.waddr = {a[ADDR_W-1:2], 2'b00};
            x.wdata = e_wdata;
            x.acc   = cyc;
            sb.push_back(x);
        end
        @(posedge clock);
        #1;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clock);
        check("drain", 32'(sb.size()), 32'd0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = 32'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_mem_read_en", 32'(mem_read_en), 32'd0);
        check("rst_mem_write_en", 32'(mem_write_en), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_error", 32'(resp_error), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_ready", 32'(req_ready), 32'd1);
        @(posedge clock);
        #1;

        // Preload with word stores (no read, write at T1, response at T3).
        issue(1, 2'b10, 0, 'h10, 32'h8877_66F5, 0, 0, 3, 0, 1, 32'h8877_66F5, 1, 0);
        issue(1, 2'b10, 0, 'h30, 32'h1122_3344, 0, 0, 3, 0, 1, 32'h1122_3344, 1, 0);
        // Byte loads.
        issue(0, 2'b00, 0, 'h11, 0, 0, 32'h0000_0066, 4, 1, 0, 0, 1, 0);
        issue(0, 2'b00, 0, 'h10, 0, 0, 32'hFFFF_FFF5, 4, 1, 0, 0, 1, 0);
        issue(0, 2'b00, 1, 'h10, 0, 0, 32'h0000_00F5, 4, 1, 0, 0, 1, 0);
        // Half store read-modify-write, then read back.
        issue(1, 2'b01, 0, 'h12, 32'h0000_ABCD, 0, 0, 5, 1, 1, 32'hABCD_66F5, 1, 0);
        issue(0, 2'b10, 0, 'h10, 0, 0, 32'hABCD_66F5, 4, 1, 0, 0, 1, 0);
        issue(0, 2'b01, 0, 'h12, 0, 0, 32'hFFFF_ABCD, 4, 1, 0, 0, 1, 0);
        issue(0, 2'b01, 1, 'h12, 0, 0, 32'h0000_ABCD, 4, 1, 0, 0, 1, 0);
        // Word store, byte store into lane 1, read back.
        issue(1, 2'b10, 0, 'h20, 32'hDEAD_BEEF, 0, 0, 3, 0, 1, 32'hDEAD_BEEF, 1, 0);
        issue(1, 2'b00, 0, 'h21, 32'h1234_565A, 0, 0, 5, 1, 1, 32'hDEAD_5AEF, 1, 0);
        issue(0, 2'b10, 0, 'h20, 0, 0, 32'hDEAD_5AEF, 4, 1, 0, 0, 1, 0);
        // Error requests: no memory traffic.
        issue(0, 2'b01, 0, 'h13, 0, 1, 0, 3, 0, 0, 0, 1, 0);
        issue(1, 2'b10, 0, 'h22, 32'h5555_5555, 1, 0, 3, 0, 0, 0, 1, 0);
        issue(0, 2'b11, 0, 'h00, 0, 1, 0, 3, 0, 0, 0, 1, 0);
        drain();

        // Byte store abandoned by a reset during the WR cycle.
        issue(1, 2'b00, 0, 'h31, 32'h0000_00EE, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("wr_gated_by_reset", 32'(mem_write_en), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("ready_after_reset", 32'(req_ready), 32'd1);
        repeat (8) @(negedge clock);
        check("abandoned_no_write", 32'(wr_cnt), 32'd0);
        rd_cnt = 0;
        wr_cnt = 0;
        @(posedge clock);
        #1;
        issue(0, 2'b10, 0, 'h30, 0, 0, 32'h1122_3344, 4, 1, 0, 0, 1, 0);

        // Back-to-back loads with req_valid held high.
        issue(0, 2'b00, 1, 'h13, 0, 0, 32'h0000_00AB, 4, 1, 0, 0, 1, 1);
        issue(0, 2'b01, 0, 'h10, 0, 0, 32'h0000_66F5, 4, 1, 0, 0, 1, 1);
        issue(0, 2'b10, 0, 'h20, 0, 0, 32'hDEAD_5AEF, 4, 1, 0, 0, 1, 0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
